// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, defaults and helpers for the clock divider
//
// Contents:
//   NCH_DEF, DW_DEF : default channel count and divisor width
//   state_t         : per-channel state encoding (ST_IDLE / ST_RUN)
//   half(n)         : (n+1)>>1, evaluated wide enough that n = 2^DW-1 cannot overflow
package clkdiv_pkg;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Callers cast the result down to DW+1 bits.
  function automatic logic [31:0] half(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel with shadowed divisor and 50% duty for odd N
//
// Ports:
//   clk      in  1   : divider clock (posedge logic, negedge retiming flop)
//   rst      in  1   : asynchronous active-high reset
//   en       in  1   : run request, level
//   div      in  DW  : divisor value captured by load
//   load     in  1   : one-cycle strobe, div -> shadow register
//   clkout   out 1   : divided clock
//   tick     out 1   : one-cycle pulse on the posedge that starts a period
//   pending  out 1   : shadow loaded but not yet applied
//   running  out 1   : channel is dividing
//   cfg_err  out 1   : active divisor below 2
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] div,
  input  logic          load,
  output logic          clkout,
  output logic          tick,
  output logic          pending,
  output logic          running,
  output logic          cfg_err
);

  state_t        st;
  logic [DW-1:0] act;
  logic [DW-1:0] shd;
  logic [DW-1:0] pc;
  logic          q_p;
  logic          q_n;

  logic          wrap;
  logic          apply;
  logic [DW-1:0] n_eff;
  logic          n_ok;
  logic          start;
  logic [DW:0]   pc_inc;
  logic [DW:0]   hi;

  assign running = (st == ST_RUN);
  assign cfg_err = (act < DW'(2));

  // Wrap is the last cycle of the period; a pending divisor is taken either
  // immediately when idle or exactly on a wrap so no phase is ever cut short.
  assign wrap   = running && (pc == act - DW'(1));
  assign apply  = pending && (!running || wrap);
  assign n_eff  = apply ? shd : act;
  assign n_ok   = (n_eff >= DW'(2));
  assign start  = en && (act >= DW'(2)) && n_ok;
  assign pc_inc = {1'b0, pc} + (DW+1)'(1);

  // q_p stays high for floor(N/2) cycles. For odd N the negedge copy q_n
  // stretches the high phase by half a cycle, so the OR rises on a posedge
  // and falls on a negedge.
  assign hi = (DW+1)'(half(32'(act))) - (DW+1)'(act[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      act     <= '0;
      shd     <= '0;
      pc      <= '0;
      q_p     <= 1'b0;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        shd <= div;
      end
      if (apply) begin
        act <= shd;
      end
      // A load on the applying edge re-arms pending for the following wrap.
      pending <= load | (pending & ~apply);

      case (st)
        ST_IDLE: begin
          if (start) begin
            st   <= ST_RUN;
            pc   <= '0;
            q_p  <= 1'b1;
            tick <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            pc <= '0;
            if (en && n_ok) begin
              q_p  <= 1'b1;
              tick <= 1'b1;
            end else begin
              st  <= ST_IDLE;
              q_p <= 1'b0;
            end
          end else begin
            pc  <= pc + DW'(1);
            q_p <= (pc_inc < hi);
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_n <= 1'b0;
    end else begin
      q_n <= q_p;
    end
  end

  // Both flops are low at every wrap, so switching parity or stopping there
  // cannot produce a glitch.
  assign clkout = running & (act[0] ? (q_p | q_n) : q_p);

endmodule

// File: rtl/clkdiv_nch.sv
// rtl/clkdiv_nch.sv - NCH independent programmable clock dividers sharing one clock
//
// Ports:
//   wb_clk_i  in  1       : shared clock
//   wb_rst_i  in  1       : asynchronous active-high reset
//   en        in  NCH     : per-channel run request
//   div       in  NCH*DW  : divisor slices, channel i at div[i*DW +: DW]
//   load      in  NCH     : per-channel shadow load strobe
//   clkout    out NCH     : divided clocks
//   tick      out NCH     : period-start pulses
//   pending   out NCH     : shadow divisor waiting to be applied
//   running   out NCH     : channel dividing
//   cfg_err   out NCH     : active divisor below 2
module clkdiv_nch
  import clkdiv_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*DW-1:0] div,
  input  logic [NCH-1:0]    load,
  output logic [NCH-1:0]    clkout,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    running,
  output logic [NCH-1:0]    cfg_err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkdiv_chan #(
      .DW(DW)
    ) u_chan (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .en      (en[i]),
      .div     (div[i*DW +: DW]),
      .load    (load[i]),
      .clkout  (clkout[i]),
      .tick    (tick[i]),
      .pending (pending[i]),
      .running (running[i]),
      .cfg_err (cfg_err[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_nch.sv
// tb/tb_clkdiv_nch.sv - directed self-checking bench for clkdiv_nch
module tb_clkdiv_nch;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] div;
  logic [3:0]  load;
  logic [3:0]  clkout;
  logic [3:0]  tick;
  logic [3:0]  pending;
  logic [3:0]  running;
  logic [3:0]  cfg_err;

  int checks = 0;
  int failures = 0;
  int k;

  logic [3:0] sa  [32];
  logic [3:0] sb  [32];
  logic [3:0] stk [32];
  logic [3:0] spd [32];
  logic [3:0] srn [32];

  clkdiv_nch #(.NCH(4), .DW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .en       (en),
    .div      (div),
    .load     (load),
    .clkout   (clkout),
    .tick     (tick),
    .pending  (pending),
    .running  (running),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples every output once 2 time units after each posedge and clkout
  // again just after the following negedge, for n consecutive cycles.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      sa[i[4:0]]  = clkout;
      stk[i[4:0]] = tick;
      spd[i[4:0]] = pending;
      srn[i[4:0]] = running;
      #5;
      sb[i[4:0]]  = clkout;
      step();
    end
  endtask

  function automatic logic [63:0] halves(input int ch, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[61:0], sa[i[4:0]][ch[1:0]], sb[i[4:0]][ch[1:0]]};
    end
    return v;
  endfunction

  // sel: 0 = tick, 1 = pending, 2 = running
  function automatic logic [63:0] cyc(input int sel, input int ch, input int n);
    logic [63:0] v;
    logic        b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      case (sel)
        0:       b = stk[i[4:0]][ch[1:0]];
        1:       b = spd[i[4:0]][ch[1:0]];
        default: b = srn[i[4:0]][ch[1:0]];
      endcase
      v = {v[62:0], b};
    end
    return v;
  endfunction

  initial begin
    rst  = 1'b1;
    en   = 4'h0;
    load = 4'h0;
    div  = 32'h0;
    repeat (3) step();
    chk("rst_clkout",  64'(clkout),  64'h0);
    chk("rst_tick",    64'(tick),    64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_running", 64'(running), 64'h0);
    chk("rst_cfg_err", 64'(cfg_err), 64'hF);
    rst = 1'b0;
    step();

    // N=4 on channel 0
    div[7:0] = 8'd4; load = 4'b0001; step();
    chk("a_pending_set", 64'(pending[0]), 64'd1);
    load = 4'b0000; step();
    chk("a_pending_clr", 64'(pending[0]), 64'd0);
    chk("a_cfg_err",     64'(cfg_err[0]), 64'd0);
    chk("a_idle",        64'(running[0]), 64'd0);
    en[0] = 1'b1; step();
    chk("a_start_clk",   64'(clkout[0]),  64'd1);
    capture(8);
    chk("a_clk_1100",  halves(0, 8),   64'hF0F0);
    chk("a_tick",      cyc(0, 0, 8),   64'h88);

    // load 6 while running N=4 at pc=1
    step();
    div[7:0] = 8'd6; load = 4'b0001; step();
    load = 4'b0000;
    chk("c_pending", 64'(pending[0]), 64'd1);
    capture(8);
    chk("c_clk",     halves(0, 8), 64'h0FC0);
    chk("c_tick",    cyc(0, 0, 8), 64'h20);
    chk("c_pending_seq", cyc(1, 0, 8), 64'hC0);

    // drop en at pc=2 of an N=6 period
    step(); step();
    en[0] = 1'b0;
    capture(8);
    chk("e_clk",     halves(0, 8), 64'hC000);
    chk("e_running", cyc(2, 0, 8), 64'hF0);
    chk("e_tick",    cyc(0, 0, 8), 64'h00);

    // invalid divisor 1, then 3
    div[7:0] = 8'd1; load = 4'b0001; step();
    load = 4'b0000; en[0] = 1'b1; step();
    chk("d_cfg_err", 64'(cfg_err[0]), 64'd1);
    chk("d_idle",    64'(running[0]), 64'd0);
    chk("d_pending", 64'(pending[0]), 64'd0);
    step();
    chk("d_idle2",   64'(running[0]), 64'd0);
    chk("d_clk0",    64'(clkout[0]),  64'd0);
    div[7:0] = 8'd3; load = 4'b0001; step();
    load = 4'b0000; step();
    chk("d3_cfg_err", 64'(cfg_err[0]), 64'd0);
    capture(6);
    chk("d3_clk",  halves(0, 6), 64'h38E);
    chk("d3_tick", cyc(0, 0, 6), 64'h12);

    // N=5 on channel 1
    div[15:8] = 8'd5; load = 4'b0010; step();
    load = 4'b0000; step();
    en[1] = 1'b1; step();
    capture(10);
    chk("b_clk",     halves(1, 10), 64'hF83E0);
    chk("b_tick",    cyc(0, 1, 10), 64'h210);
    chk("b_cfg_err", 64'(cfg_err[1]), 64'd0);

    // all four channels, reset in the high phase
    en = 4'h0;
    repeat (6) step();
    chk("f_idle", 64'(running), 64'h0);
    div = {8'd255, 8'd7, 8'd3, 8'd2}; load = 4'hF; step();
    load = 4'h0; step();
    en = 4'hF; step();
    chk("f_all_high", 64'(clkout), 64'hF);
    chk("f_all_tick", 64'(tick),   64'hF);
    rst = 1'b1;
    #1;
    chk("f_rst_clkout",  64'(clkout),  64'h0);
    chk("f_rst_tick",    64'(tick),    64'h0);
    chk("f_rst_running", 64'(running), 64'h0);
    chk("f_rst_cfg_err", 64'(cfg_err), 64'hF);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("f_no_run_wo_load", 64'(running), 64'h0);
    chk("f_no_clk_wo_load", 64'(clkout),  64'h0);
    en = 4'h0; load = 4'hF; step();
    load = 4'h0; step();
    en = 4'b0101; step();
    en = 4'hF;
    capture(8);
    chk("f_ch0_clk",  halves(0, 8), 64'hCCCC);
    chk("f_ch0_tick", cyc(0, 0, 8), 64'hAA);
    chk("f_ch1_clk",  halves(1, 8), 64'h38E3);
    chk("f_ch1_tick", cyc(0, 1, 8), 64'h49);
    chk("f_ch2_clk",  halves(2, 8), 64'hFE03);
    chk("f_ch2_tick", cyc(0, 2, 8), 64'h81);
    chk("f_ch3_clk",  halves(3, 8), 64'h3FFF);
    chk("f_ch3_tick", cyc(0, 3, 8), 64'h40);
    chk("f_cfg_err",  64'(cfg_err), 64'h0);
    k = 0;
    while (tick[3] !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    chk("f_n255_period", 64'(k), 64'd248);

    // load on a wrap edge while a load is already pending (channel 0, N=2)
    k = 0;
    while (tick[0] !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("g_sync", 64'(tick[0]), 64'd1);
    div[7:0] = 8'd6; load = 4'b0001; step();
    chk("g_pending", 64'(pending[0]), 64'd1);
    div[7:0] = 8'd4; step();
    load = 4'b0000;
    capture(8);
    chk("g_clk",     halves(0, 8), 64'hFC0F);
    chk("g_pending_seq", cyc(1, 0, 8), 64'hFC);
    chk("g_tick",    cyc(0, 0, 8), 64'h82);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
